game_sprite_control: RTL and testbench

//   Upstream motion controller for one game sprite. Owns the sprite's screen

---
 rtl/game_sprite_control.sv | 145 ++++++++++++++
 tb/tb_game_sprite_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sprite_control.sv
// Motion controller for one game sprite: owns position and life cycle
// (idle / moving / hit) and drives registered x/y into the display stage.
module game_sprite_control #(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int D_WIDTH    = 4,
  parameter int SPEED_DIV  = 1,
  parameter int HIT_FRAMES = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_tick_i,
  input  logic               launch_i,
  input  logic [X_WIDTH-1:0] init_x_i,
  input  logic [Y_WIDTH-1:0] init_y_i,
  input  logic [D_WIDTH-1:0] dx_i,
  input  logic [D_WIDTH-1:0] dy_i,
  input  logic               collision_i,
  input  logic               sprite_out_of_screen_i,
  output logic [X_WIDTH-1:0] sprite_x_o,
  output logic [Y_WIDTH-1:0] sprite_y_o,
  output logic               sprite_active_o,
  output logic               sprite_hit_o,
  output logic               done_o
);

  localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_HIT    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [D_WIDTH-1:0] dx_q, dx_d;
  logic [D_WIDTH-1:0] dy_q, dy_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HIT_W-1:0]   hcnt_q, hcnt_d;
  logic               act_q, act_d;
  logic               hit_q, hit_d;
  logic               done_q, done_d;

  logic [X_WIDTH-1:0] x_step;
  logic [Y_WIDTH-1:0] y_step;
  logic               load;

  // Velocity is two's complement; sums wrap naturally at the coordinate width.
  assign x_step = x_q + {{(X_WIDTH-D_WIDTH){dx_q[D_WIDTH-1]}}, dx_q};
  assign y_step = y_q + {{(Y_WIDTH-D_WIDTH){dy_q[D_WIDTH-1]}}, dy_q};
  assign load   = launch_i && (state_q != ST_HIT);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;

    if (load) begin
      state_d = ST_MOVING;
      x_d     = init_x_i;
      y_d     = init_y_i;
      dx_d    = dx_i;
      dy_d    = dy_i;
      div_d   = '0;
    end else begin
      unique case (state_q)
        ST_MOVING: begin
          if (collision_i) begin
            state_d = ST_HIT;
            hcnt_d  = '0;
          end else if (frame_tick_i) begin
            if (sprite_out_of_screen_i) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (div_q == DIV_LAST) begin
              x_d   = x_step;
              y_d   = y_step;
              div_d = '0;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        ST_HIT: begin
          if (frame_tick_i) begin
            if (hcnt_q == HIT_LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Flags follow the next state so they are registered alongside it.
    act_d = (state_d != ST_IDLE);
    hit_d = (state_d == ST_HIT);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      div_q   <= '0;
      hcnt_q  <= '0;
      act_q   <= 1'b0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      act_q   <= act_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  assign sprite_x_o      = x_q;
  assign sprite_y_o      = y_q;
  assign sprite_active_o = act_q;
  assign sprite_hit_o    = hit_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_game_sprite_control.sv
// Bench for game_sprite_control: two instances (step every tick / every 4th
// tick) driven in lockstep and compared against a frame-level reference model.
module tb_game_sprite_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, launch, collision, oos;
  logic [9:0] init_x, init_y;
  logic [3:0] dx, dy;

  logic [9:0] sx  [2];
  logic [9:0] sy  [2];
  logic       act [2];
  logic       hit [2];
  logic       dn  [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state: mode 0 idle, 1 moving, 2 hit.
  int m_mode [2];
  int m_x [2], m_y [2], m_dx [2], m_dy [2];
  int m_since_step [2];
  int m_hit_left [2];
  int m_done [2];
  int div_of [2] = '{1, 4};

  always #5 clk = ~clk;

  game_sprite_control #(.SPEED_DIV(1), .HIT_FRAMES(16)) u_div1 (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick), .launch_i(launch),
    .init_x_i(init_x), .init_y_i(init_y), .dx_i(dx), .dy_i(dy),
    .collision_i(collision), .sprite_out_of_screen_i(oos),
    .sprite_x_o(sx[0]), .sprite_y_o(sy[0]), .sprite_active_o(act[0]),
    .sprite_hit_o(hit[0]), .done_o(dn[0]));

  game_sprite_control #(.SPEED_DIV(4), .HIT_FRAMES(16)) u_div4 (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick), .launch_i(launch),
    .init_x_i(init_x), .init_y_i(init_y), .dx_i(dx), .dy_i(dy),
    .collision_i(collision), .sprite_out_of_screen_i(oos),
    .sprite_x_o(sx[1]), .sprite_y_o(sy[1]), .sprite_active_o(act[1]),
    .sprite_hit_o(hit[1]), .done_o(dn[1]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sext4(input logic [3:0] v);
    int s = int'(v);
    if (s > 7) s -= 16;
    return s;
  endfunction

  function automatic int wrap10(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
      m_since_step[i] = 0; m_hit_left[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock edge of sprite behaviour, written from the frame-level rules.
  task automatic model_update();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (launch && m_mode[i] != 2) begin
        m_mode[i] = 1; m_x[i] = init_x; m_y[i] = init_y;
        m_dx[i] = sext4(dx); m_dy[i] = sext4(dy); m_since_step[i] = 0;
      end else if (m_mode[i] == 1) begin
        if (collision) begin
          m_mode[i] = 2; m_hit_left[i] = 16;
        end else if (frame_tick) begin
          if (oos) begin
            m_mode[i] = 0; m_done[i] = 1;
          end else begin
            m_since_step[i]++;
            if (m_since_step[i] == div_of[i]) begin
              m_x[i] = wrap10(m_x[i] + m_dx[i]);
              m_y[i] = wrap10(m_y[i] + m_dy[i]);
              m_since_step[i] = 0;
            end
          end
        end
      end else if (m_mode[i] == 2 && frame_tick) begin
        m_hit_left[i]--;
        if (m_hit_left[i] == 0) begin
          m_mode[i] = 0; m_done[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("x%0d", i),      int'(sx[i]),  m_x[i]);
      chk($sformatf("y%0d", i),      int'(sy[i]),  m_y[i]);
      chk($sformatf("active%0d", i), int'(act[i]), (m_mode[i] != 0) ? 1 : 0);
      chk($sformatf("hit%0d", i),    int'(hit[i]), (m_mode[i] == 2) ? 1 : 0);
      chk($sformatf("done%0d", i),   int'(dn[i]),  m_done[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic l, input logic c, input logic t, input logic o);
    launch = l; collision = c; frame_tick = t; oos = o;
  endtask

  task automatic set_launch(input int x, input int y, input int vx, input int vy);
    init_x = 10'(x); init_y = 10'(y); dx = 4'(vx); dy = 4'(vy);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    set_launch(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Basic motion: (100,200) +3/-2 per tick on the undivided instance.
    set_launch(100, 200, 3, -2);
    set_in(1, 0, 0, 0); step();
    chk("launch_x", int'(sx[0]), 100);
    chk("launch_active", int'(act[0]), 1);
    set_in(0, 0, 1, 0); step(); chk("t1_x", int'(sx[0]), 103); chk("t1_y", int'(sy[0]), 198);
    set_in(0, 0, 0, 0); step();
    set_in(0, 0, 1, 0); step(); chk("t2_x", int'(sx[0]), 106); chk("t2_y", int'(sy[0]), 196);
    set_in(0, 0, 1, 0); step(); chk("t3_x", int'(sx[0]), 109); chk("t3_y", int'(sy[0]), 194);

    // Divided instance steps only on every fourth tick.
    set_launch(100, 200, 1, 0);
    set_in(1, 0, 0, 0); step();
    for (int k = 1; k <= 12; k++) begin
      set_in(0, 0, 1, 0); step();
      if (k == 3) chk("div4_t3_x", int'(sx[1]), 100);
      if (k == 4) chk("div4_t4_x", int'(sx[1]), 101);
    end
    chk("div4_t12_x", int'(sx[1]), 103);

    // Coordinate wrap in both directions.
    set_launch(1020, 2, 7, -5);
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    chk("wrap_x", int'(sx[0]), 3);
    chk("wrap_y", int'(sy[0]), 1021);

    // Off-screen retire: no step, single done pulse, later ticks inert.
    set_launch(500, 400, 2, 2);
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 1, 1); step();
    chk("oos_x", int'(sx[0]), 500);
    chk("oos_active", int'(act[0]), 0);
    chk("oos_done", int'(dn[0]), 1);
    set_in(0, 0, 1, 0); step();
    chk("oos_done_gone", int'(dn[0]), 0);
    set_in(0, 0, 1, 0); step();
    chk("idle_hold_x", int'(sx[0]), 500);

    // Collision: hit pose, launch ignored, exit on the sixteenth tick.
    set_launch(300, 300, 1, 1);
    set_in(1, 0, 0, 0); step();
    set_in(0, 1, 0, 0); step();
    chk("hit_flag", int'(hit[0]), 1);
    set_launch(10, 10, 0, 0);
    set_in(1, 1, 0, 0); step();
    chk("hit_launch_ignored_x", int'(sx[0]), 300);
    for (int k = 1; k <= 16; k++) begin
      set_in(0, 0, 1, 0); step();
      if (k == 15) chk("hit_t15", int'(hit[0]), 1);
    end
    chk("hit_exit_active", int'(act[0]), 0);
    chk("hit_exit_hit", int'(hit[0]), 0);
    chk("hit_exit_done", int'(dn[0]), 1);

    // Launch and tick together while moving: reload wins, no step.
    set_launch(40, 40, 3, 3);
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    set_launch(50, 60, 3, 1);
    set_in(1, 0, 1, 0); step();
    chk("launch_tick_x", int'(sx[0]), 50);
    chk("launch_tick_y", int'(sy[0]), 60);

    // Asynchronous reset mid-motion.
    set_in(0, 0, 1, 0); step();
    set_in(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("areset_x", int'(sx[i]), 0);
      chk("areset_y", int'(sy[i]), 0);
      chk("areset_active", int'(act[i]), 0);
      chk("areset_hit", int'(hit[i]), 0);
      chk("areset_done", int'(dn[i]), 0);
    end
    model_reset();
    step();
    reset = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      set_launch($urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 14) == 0));
      if ($urandom_range(0, 599) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
